// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the post-commit store buffer.
package store_buffer_pkg;

    localparam int unsigned SB_ENTRIES  = 4;
    localparam int unsigned SB_WORD_OFF = 2;
    localparam int unsigned SB_ADDR_W   = 32;
    localparam int unsigned SB_DATA_W   = 32;

    // One committed store; field widths are fixed here, and the top-level width parameters must match them.
    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic                 is_byte;
    } sb_entry_t;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_REQ  = 1'b1
    } sb_state_e;

endpackage : store_buffer_pkg

// File: rtl/sb_fwd.sv
// Combinational load-forwarding search over the live store-buffer entries.
module sb_fwd
    import store_buffer_pkg::*;
#(
    parameter int unsigned N      = SB_ENTRIES,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W
) (
    input  sb_entry_t             entries [N],
    input  logic [$clog2(N)-1:0]  head,
    input  logic [$clog2(N):0]    count,
    input  logic                  ld_valid,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic                  ld_byte,
    output logic                  hit_c,
    output logic                  stall_c,
    output logic [DATA_W-1:0]     data_c
);

    localparam int unsigned PTR_W = $clog2(N);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;
    sb_entry_t        e;

    // Walk oldest to youngest so the youngest deciding entry wins; a byte store to a different byte decides nothing.
    always_comb begin
        hit_c   = 1'b0;
        stall_c = 1'b0;
        data_c  = '0;
        idx     = '0;
        e       = '0;
        if (ld_valid) begin
            for (int unsigned i = 0; i < N; i++) begin
                idx = head + PTR_W'(i);
                e   = entries[idx];
                if ((CNT_W'(i) < count) && e.valid &&
                    (e.addr[ADDR_W-1:SB_WORD_OFF] == ld_addr[ADDR_W-1:SB_WORD_OFF])) begin
                    if (!e.is_byte) begin
                        hit_c   = 1'b1;
                        stall_c = 1'b0;
                        data_c  = ld_byte ? DATA_W'(e.data[{ld_addr[SB_WORD_OFF-1:0], 3'b000} +: 8])
                                          : e.data;
                    end else if (!ld_byte) begin
                        hit_c   = 1'b0;
                        stall_c = 1'b1;
                        data_c  = '0;
                    end else if (e.addr[SB_WORD_OFF-1:0] == ld_addr[SB_WORD_OFF-1:0]) begin
                        hit_c   = 1'b1;
                        stall_c = 1'b0;
                        data_c  = DATA_W'(e.data[7:0]);
                    end
                end
            end
        end
    end

endmodule : sb_fwd

// File: rtl/store_buffer.sv
// Post-commit store FIFO draining to the dcache, with forwarding to younger loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned ENTRIES = SB_ENTRIES,
    parameter int unsigned ADDR_W  = SB_ADDR_W,
    parameter int unsigned DATA_W  = SB_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cm_valid,
    input  logic [ADDR_W-1:0]          cm_addr,
    input  logic [DATA_W-1:0]          cm_data,
    input  logic                       cm_byte,
    output logic                       cm_ready,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    input  logic                       ld_byte,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       ld_stall,
    output logic                       dc_req,
    output logic [ADDR_W-1:0]          dc_addr,
    output logic [DATA_W-1:0]          dc_data,
    output logic                       dc_byte,
    input  logic                       dc_ack,
    output logic                       empty,
    output logic [$clog2(ENTRIES):0]   count
);

    localparam int unsigned PTR_W = $clog2(ENTRIES);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_state_e        state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    sb_entry_t        entries_q [ENTRIES];
    sb_entry_t        entries_d [ENTRIES];

    logic      full_c;
    logic      push_c;
    logic      pop_c;
    sb_entry_t head_e;

    assign full_c   = (count_q == CNT_W'(ENTRIES));
    assign push_c   = cm_valid & ~full_c;
    assign pop_c    = (state_q == SB_REQ) & dc_ack;
    assign head_e   = entries_q[head_q];

    assign cm_ready = ~full_c;
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign dc_req   = (state_q == SB_REQ);
    assign dc_addr  = dc_req ? head_e.addr    : '0;
    assign dc_data  = dc_req ? head_e.data    : '0;
    assign dc_byte  = dc_req ? head_e.is_byte : 1'b0;

    // FIFO datapath: write at tail on push, retire head on dcache ack.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        if (push_c) begin
            entries_d[tail_q] = '{valid: 1'b1, addr: cm_addr, data: cm_data, is_byte: cm_byte};
            tail_d            = tail_q + PTR_W'(1);
        end
        if (pop_c) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + PTR_W'(1);
        end
    end

    // Drain FSM: request while entries remain, drop back to idle when the last one is acked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_IDLE: if (count_q != '0) state_d = SB_REQ;
            SB_REQ:  if (pop_c && (count_d == '0)) state_d = SB_IDLE;
            default: state_d = SB_IDLE;
        endcase
    end

    // State registers; reset discards every buffered store at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SB_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    sb_fwd #(
        .N      (ENTRIES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .entries  (entries_q),
        .head     (head_q),
        .count    (count_q),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_byte  (ld_byte),
        .hit_c    (ld_hit),
        .stall_c  (ld_stall),
        .data_c   (ld_data)
    );

endmodule : store_buffer

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        cm_valid;
    logic [31:0] cm_addr;
    logic [31:0] cm_data;
    logic        cm_byte;
    logic        cm_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_byte;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        dc_req;
    logic [31:0] dc_addr;
    logic [31:0] dc_data;
    logic        dc_byte;
    logic        dc_ack;
    logic        empty;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    store_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .cm_valid (cm_valid),
        .cm_addr  (cm_addr),
        .cm_data  (cm_data),
        .cm_byte  (cm_byte),
        .cm_ready (cm_ready),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_byte  (ld_byte),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .ld_stall (ld_stall),
        .dc_req   (dc_req),
        .dc_addr  (dc_addr),
        .dc_data  (dc_data),
        .dc_byte  (dc_byte),
        .dc_ack   (dc_ack),
        .empty    (empty),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic b);
        cm_valid = 1'b1;
        cm_addr  = a;
        cm_data  = d;
        cm_byte  = b;
        step();
        cm_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic b);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_byte  = b;
        #1;
    endtask

    // Push n word stores with dc_ack held high; every drain must follow the previous one by one cycle.
    task automatic drain_run(input int n, input logic [31:0] base);
        int pushed = 0;
        int popped = 0;
        int cyc    = 0;
        int last   = -1;
        dc_ack = 1'b1;
        while (popped < n && cyc < 40) begin
            cm_valid = (pushed < n);
            cm_addr  = base + 32'(4 * pushed);
            cm_data  = 32'hA000_0000 + 32'(pushed);
            cm_byte  = 1'b0;
            if (dc_req) begin
                check("drain_addr", dc_addr, base + 32'(4 * popped));
                check("drain_data", dc_data, 32'hA000_0000 + 32'(popped));
                if (last >= 0) check("drain_gap", 32'(cyc - last), 32'd1);
                last = cyc;
                popped++;
            end
            if (cm_valid && cm_ready) pushed++;
            step();
            cyc++;
        end
        cm_valid = 1'b0;
        dc_ack   = 1'b0;
        check("drain_done", 32'(popped), 32'(n));
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_idle", 32'(dc_req), 32'd0);
        check("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        cm_valid = 1'b0;
        cm_addr  = '0;
        cm_data  = '0;
        cm_byte  = 1'b0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_byte  = 1'b0;
        dc_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(cm_ready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_dcreq", 32'(dc_req), 32'd0);
        check("rst_dcaddr", dc_addr, 32'd0);
        check("rst_hit", 32'(ld_hit), 32'd0);
        check("rst_ldata", ld_data, 32'd0);
        reset = 1'b0;
        step();

        // Single store: count, request timing, forwarding.
        push(32'h100, 32'hDEADBEEF, 1'b0);
        check("t1_count", 32'(count), 32'd1);
        check("t1_noreq_yet", 32'(dc_req), 32'd0);
        load(32'h100, 1'b0);
        check("t1_hit", 32'(ld_hit), 32'd1);
        check("t1_ldata", ld_data, 32'hDEADBEEF);
        ld_valid = 1'b0;
        #1;
        check("t1_novalid_hit", 32'(ld_hit), 32'd0);
        step();
        check("t1_req", 32'(dc_req), 32'd1);
        check("t1_dcaddr", dc_addr, 32'h100);
        check("t1_dcdata", dc_data, 32'hDEADBEEF);
        dc_ack = 1'b1;
        step();
        dc_ack = 1'b0;
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_idle", 32'(dc_req), 32'd0);
        load(32'h100, 1'b0);
        check("t1_popped_hit", 32'(ld_hit), 32'd0);
        ld_valid = 1'b0;

        // Fill to full, reject a fifth commit, then a full-cycle ack with a commit.
        for (int k = 0; k < 4; k++) push(32'h300 + 32'(4 * k), 32'hB000_0000 + 32'(k), 1'b0);
        check("t2_count", 32'(count), 32'd4);
        check("t2_ready", 32'(cm_ready), 32'd0);
        check("t2_head", dc_addr, 32'h300);
        push(32'h400, 32'hCAFE0000, 1'b0);
        check("t2_count_full", 32'(count), 32'd4);
        load(32'h400, 1'b0);
        check("t2_reject_hit", 32'(ld_hit), 32'd0);
        ld_valid = 1'b0;
        dc_ack   = 1'b1;
        cm_valid = 1'b1;
        cm_addr  = 32'h500;
        cm_data  = 32'h5555_5555;
        check("t5_ready_pre", 32'(cm_ready), 32'd0);
        step();
        cm_valid = 1'b0;
        dc_ack   = 1'b0;
        check("t5_count", 32'(count), 32'd3);
        check("t5_head", dc_addr, 32'h304);
        load(32'h500, 1'b0);
        check("t5_reject_hit", 32'(ld_hit), 32'd0);
        load(32'h300, 1'b0);
        check("t5_popped_hit", 32'(ld_hit), 32'd0);
        load(32'h308, 1'b0);
        check("t5_live_data", ld_data, 32'hB000_0002);
        ld_valid = 1'b0;
        dc_ack   = 1'b1;
        repeat (3) step();
        dc_ack = 1'b0;
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_idle", 32'(dc_req), 32'd0);

        // Mixed word/byte overlap.
        push(32'h200, 32'h11223344, 1'b0);
        push(32'h201, 32'h000000AA, 1'b1);
        load(32'h201, 1'b1);
        check("t3_b201_hit", 32'(ld_hit), 32'd1);
        check("t3_b201", ld_data, 32'h0000_00AA);
        load(32'h202, 1'b1);
        check("t3_b202_hit", 32'(ld_hit), 32'd1);
        check("t3_b202", ld_data, 32'h0000_0022);
        load(32'h200, 1'b1);
        check("t3_b200", ld_data, 32'h0000_0044);
        load(32'h200, 1'b0);
        check("t3_w_stall", 32'(ld_stall), 32'd1);
        check("t3_w_hit", 32'(ld_hit), 32'd0);
        ld_valid = 1'b0;
        #1;
        check("t3_novalid_stall", 32'(ld_stall), 32'd0);
        step();
        check("t3_dcbyte_head", 32'(dc_byte), 32'd0);
        dc_ack = 1'b1;
        step();
        check("t3_dcbyte_next", 32'(dc_byte), 32'd1);
        check("t3_dcaddr_next", dc_addr, 32'h201);
        step();
        dc_ack = 1'b0;
        check("t3_empty", 32'(empty), 32'd1);

        // Back-to-back drains, then a longer run across the pointer wrap.
        drain_run(3, 32'h600);
        drain_run(6, 32'h700);

        // Asynchronous reset mid-drain.
        push(32'h800, 32'h0000_8888, 1'b0);
        push(32'h804, 32'h0000_9999, 1'b0);
        check("t6_req", 32'(dc_req), 32'd1);
        check("t6_count", 32'(count), 32'd2);
        #1;
        reset = 1'b1;
        #1;
        check("t6_req_rst", 32'(dc_req), 32'd0);
        check("t6_empty_rst", 32'(empty), 32'd1);
        check("t6_count_rst", 32'(count), 32'd0);
        check("t6_dcaddr_rst", dc_addr, 32'd0);
        step();
        reset = 1'b0;
        step();
        load(32'h800, 1'b0);
        check("t6_hit_after", 32'(ld_hit), 32'd0);
        ld_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_store_buffer
